// File: rtl/sst_pkg.sv
// sst_pkg: shared state encoding, direction constants and register-address type
//   for the save-state sequencer and its helpers.
package sst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S_ADDR,
        S_CAP,
        S_WAIT,
        R_REQ,
        R_WAIT,
        R_WR,
        FIN
    } sst_seq_st_t;

    localparam logic SST_SAVE    = 1'b0;
    localparam logic SST_RESTORE = 1'b1;

    typedef logic [7:0] sst_reg_t;

endpackage

// File: rtl/sst_tmo.sv
// sst_tmo: wait-cycle counter that flags the cycle in which the TMO-th wait elapses.
//   clk  in  block clock, counts on falling edge
//   rst  in  synchronous active-high reset
//   clr  in  reload the count to zero (issued on entry to a wait state)
//   en   in  a wait cycle is elapsing
//   tc   out this wait cycle is the TMO-th one
module sst_tmo #(
    parameter int TMO = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TMO + 1);

    logic [W-1:0] cnt;

    assign tc = en && cnt == W'(TMO - 1);

    always_ff @(negedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sst_seq.sv
// sst_seq: save-state sequencer, initiator on the mapper save-state register bus.
//   SAVE walks REG_FIRST..REG_LAST, reading each register and writing it to snapshot
//   memory; RESTORE reads memory and writes each value back over the register bus.
//   cpu_m2      in  block clock, all state changes on its falling edge
//   map_rst     in  synchronous active-high reset
//   cmd_start   in  start pulse, accepted only when idle
//   cmd_restore in  direction sampled with cmd_start (0 save, 1 restore)
//   cmd_abort   in  terminate the current operation
//   busy, done, err, sst_act      out status / save-state mode
//   sst_addr, sst_we_reg, sst_dato out register bus, sst_di in read data
//   mem_addr, mem_we, mem_re, mem_dout out memory request, mem_din/mem_rdy in
import sst_pkg::*;

module sst_seq #(
    parameter int REG_FIRST = 0,
    parameter int REG_LAST  = 255,
    parameter int MEM_AW    = 16,
    parameter int MEM_BASE  = 0,
    parameter int TMO       = 1023
) (
    input  logic              cpu_m2,
    input  logic              map_rst,
    input  logic              cmd_start,
    input  logic              cmd_restore,
    input  logic              cmd_abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sst_act,
    output logic [7:0]        sst_addr,
    output logic              sst_we_reg,
    output logic [7:0]        sst_dato,
    input  logic [7:0]        sst_di,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    input  logic              mem_rdy
);

    localparam sst_reg_t FIRST = sst_reg_t'(REG_FIRST);
    localparam sst_reg_t LAST  = sst_reg_t'(REG_LAST);

    sst_seq_st_t state;
    sst_reg_t    idx;
    sst_reg_t    nxt;
    logic        last;
    logic        tmo_tc;

    function automatic logic [MEM_AW-1:0] maddr(input sst_reg_t i);
        return MEM_AW'(MEM_BASE + int'(i) - REG_FIRST);
    endfunction

    assign nxt  = idx + 8'd1;
    assign last = idx == LAST;

    // Count reloads while in the request cycle, so it reads zero on entering a wait state.
    sst_tmo #(.TMO(TMO)) u_tmo (
        .clk (cpu_m2),
        .rst (map_rst),
        .clr (state == S_CAP || state == R_REQ),
        .en  ((state == S_WAIT || state == R_WAIT) && !mem_rdy),
        .tc  (tmo_tc)
    );

    // Outputs are registered as state-entry actions: mem_we is already high in S_CAP
    // and mem_re in R_REQ, so a responder answering the following cycle keeps the
    // loop at three cycles per register.
    always_ff @(negedge cpu_m2) begin
        if (map_rst) begin
            state      <= IDLE;
            idx        <= FIRST;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            sst_act    <= 1'b0;
            sst_addr   <= '0;
            sst_we_reg <= 1'b0;
            sst_dato   <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_dout   <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && cmd_abort) begin
                state      <= IDLE;
                idx        <= FIRST;
                busy       <= 1'b0;
                sst_act    <= 1'b0;
                sst_we_reg <= 1'b0;
                mem_we     <= 1'b0;
                mem_re     <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cmd_start) begin
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        sst_act  <= 1'b1;
                        idx      <= FIRST;
                        sst_addr <= FIRST;
                        mem_addr <= maddr(FIRST);
                        mem_re   <= cmd_restore == SST_RESTORE;
                        state    <= cmd_restore == SST_RESTORE ? R_REQ : S_ADDR;
                    end
                    // sst_addr has been stable for this whole cycle; take the read value.
                    S_ADDR: begin
                        mem_dout <= sst_di;
                        mem_we   <= 1'b1;
                        state    <= S_CAP;
                    end
                    S_CAP: state <= S_WAIT;
                    S_WAIT: if (mem_rdy) begin
                        mem_we <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx      <= nxt;
                            sst_addr <= nxt;
                            mem_addr <= maddr(nxt);
                            state    <= S_ADDR;
                        end
                    end else if (tmo_tc) begin
                        err     <= 1'b1;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        sst_act <= 1'b0;
                        idx     <= FIRST;
                        state   <= IDLE;
                    end
                    R_REQ: state <= R_WAIT;
                    R_WAIT: if (mem_rdy) begin
                        sst_dato   <= mem_din;
                        mem_re     <= 1'b0;
                        sst_we_reg <= 1'b1;
                        state      <= R_WR;
                    end else if (tmo_tc) begin
                        err     <= 1'b1;
                        mem_re  <= 1'b0;
                        busy    <= 1'b0;
                        sst_act <= 1'b0;
                        idx     <= FIRST;
                        state   <= IDLE;
                    end
                    R_WR: begin
                        sst_we_reg <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx      <= nxt;
                            sst_addr <= nxt;
                            mem_addr <= maddr(nxt);
                            mem_re   <= 1'b1;
                            state    <= R_REQ;
                        end
                    end
                    FIN: begin
                        busy    <= 1'b0;
                        sst_act <= 1'b0;
                        idx     <= FIRST;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
